// File: rtl/dec_bcd_entry_if.sv
// Handshake/bus bundle for dec_bcd_entry; bin_out is present only when DEC_BCD_BIN_EN is defined.
// master = the entry block (sources the committed value), slave = keypad driver / consumer side.
interface dec_bcd_entry_if #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 14
);
   localparam int unsigned CW = $clog2(DIGITS + 1);

   logic [9:0]          key;
   logic                clr;
   logic                enter;
   logic                out_ready;
   logic [4*DIGITS-1:0] bcd_out;
   logic [CW-1:0]       count;
   logic                out_valid;
   logic                err;
   logic                ovf;
`ifdef DEC_BCD_BIN_EN
   logic [BIN_W-1:0]    bin_out;
`endif

   if (DIGITS < 1 || DIGITS > 8 || BIN_W < 1) begin : g_param_chk
      $error("dec_bcd_entry_if: DIGITS must be 1..8 and BIN_W nonzero");
   end

   modport master (
      input  key, clr, enter, out_ready,
      output bcd_out, count, out_valid, err, ovf
`ifdef DEC_BCD_BIN_EN
      , output bin_out
`endif
   );

   modport slave (
      output key, clr, enter, out_ready,
      input  bcd_out, count, out_valid, err, ovf
`ifdef DEC_BCD_BIN_EN
      , input  bin_out
`endif
   );
endinterface

// File: rtl/dec_bcd_entry.sv
// Multi-digit decimal key entry into a packed BCD register with valid/ready commit.
// Optional binary accumulator enabled by defining DEC_BCD_BIN_EN.
module dec_bcd_entry #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 14
) (
   input  logic            clk,
   input  logic            rst,
   dec_bcd_entry_if.master bus
);
   localparam int unsigned CW    = $clog2(DIGITS + 1);
   localparam int unsigned BCD_W = 4 * DIGITS;

   if (DIGITS < 1 || DIGITS > 8 || BIN_W < 1) begin : g_param_chk
      $error("dec_bcd_entry: DIGITS must be 1..8 and BIN_W nonzero");
   end

   typedef enum logic {ST_ENTRY, ST_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [9:0]        r_key_q;
   logic [BCD_W-1:0]  r_bcd, w_bcd_nxt, w_bcd_shift;
   logic [CW-1:0]     r_count, w_count_nxt;
   logic              r_err, w_err_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic              w_press, w_onehot, w_full, w_xfer, w_accept;
   logic [3:0]        w_digit;
`ifdef DEC_BCD_BIN_EN
   logic [BIN_W-1:0]  r_bin, w_bin_nxt;
`endif

   assign w_press  = (bus.key != '0) && (r_key_q == '0);
   assign w_onehot = $onehot(bus.key);
   assign w_full   = (r_count == CW'(DIGITS));
   assign w_xfer   = (r_state == ST_DONE) && bus.out_ready;
   assign w_accept = (r_state == ST_ENTRY) && w_press && w_onehot && !w_full;
   // Truncating cast drops the oldest nibble; also valid for DIGITS == 1.
   assign w_bcd_shift = BCD_W'({r_bcd, w_digit});

   always_comb begin
      w_digit = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (bus.key[i]) w_digit = 4'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clr) r_state <= ST_ENTRY;
      else                r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ENTRY: if (bus.enter) w_state_nxt = ST_DONE;
         ST_DONE:  if (w_xfer)    w_state_nxt = ST_ENTRY;
         default:                 w_state_nxt = ST_ENTRY;
      endcase
   end

   always_comb begin
      w_bcd_nxt   = r_bcd;
      w_count_nxt = r_count;
      w_err_nxt   = 1'b0;
      w_ovf_nxt   = 1'b0;
`ifdef DEC_BCD_BIN_EN
      w_bin_nxt   = r_bin;
`endif
      case (r_state)
         ST_ENTRY: begin
            if (w_press && !w_onehot) w_err_nxt = 1'b1;
            else if (w_press && w_full) w_ovf_nxt = 1'b1;
            if (w_accept) begin
               w_bcd_nxt   = w_bcd_shift;
               w_count_nxt = r_count + CW'(1);
`ifdef DEC_BCD_BIN_EN
               w_bin_nxt   = r_bin * BIN_W'(10) + BIN_W'(w_digit);
`endif
            end
         end
         ST_DONE: begin
            if (w_xfer) begin
               w_bcd_nxt   = '0;
               w_count_nxt = '0;
`ifdef DEC_BCD_BIN_EN
               w_bin_nxt   = '0;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         r_key_q <= '0;
         r_bcd   <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
         r_ovf   <= 1'b0;
`ifdef DEC_BCD_BIN_EN
         r_bin   <= '0;
`endif
      end else begin
         r_key_q <= bus.key;
         r_bcd   <= w_bcd_nxt;
         r_count <= w_count_nxt;
         r_err   <= w_err_nxt;
         r_ovf   <= w_ovf_nxt;
`ifdef DEC_BCD_BIN_EN
         r_bin   <= w_bin_nxt;
`endif
      end
   end

   assign bus.bcd_out   = r_bcd;
   assign bus.count     = r_count;
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.err       = r_err;
   assign bus.ovf       = r_ovf;
`ifdef DEC_BCD_BIN_EN
   assign bus.bin_out   = r_bin;
`endif
endmodule

// File: tb/tb_dec_bcd_entry.sv
// Directed self-checking bench for dec_bcd_entry (DIGITS=4); bin_out checked when DEC_BCD_BIN_EN is defined.
module tb_dec_bcd_entry;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   dec_bcd_entry_if #(.DIGITS(4), .BIN_W(14)) bus ();

   dec_bcd_entry #(.DIGITS(4), .BIN_W(14)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick(input int unsigned n = 1);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_digit(input int unsigned d);
      logic [9:0] k;
      k = 10'd1 << d;
      bus.key = k;
      tick(3);
      bus.key = '0;
      tick(2);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_bcd"},   32'(bus.bcd_out),   32'd0);
      chk({tag, "_count"}, 32'(bus.count),     32'd0);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_err"},   32'(bus.err),       32'd0);
      chk({tag, "_ovf"},   32'(bus.ovf),       32'd0);
`ifdef DEC_BCD_BIN_EN
      chk({tag, "_bin"},   32'(bus.bin_out),   32'd0);
`endif
   endtask

   initial begin
      bus.key = '0; bus.clr = 1'b0; bus.enter = 1'b0; bus.out_ready = 1'b0;
      tick(2);
      rst = 1'b0;
      chk_idle("reset");

      // 1 9 8 4, then overflow with 7
      press_digit(1); press_digit(9); press_digit(8); press_digit(4);
      chk("e1984_bcd",   32'(bus.bcd_out), 32'h1984);
      chk("e1984_count", 32'(bus.count),   32'd4);
      bus.key = 10'd1 << 7;
      tick();
      chk("ovf_pulse", 32'(bus.ovf),     32'd1);
      chk("ovf_bcd",   32'(bus.bcd_out), 32'h1984);
      chk("ovf_count", 32'(bus.count),   32'd4);
      tick();
      chk("ovf_width", 32'(bus.ovf), 32'd0);
      bus.key = '0;
      tick(2);
      bus.enter = 1'b1;
      tick();
      bus.enter = 1'b0;
      chk("commit_valid", 32'(bus.out_valid), 32'd1);
      chk("commit_bcd",   32'(bus.bcd_out),   32'h1984);
      chk("commit_count", 32'(bus.count),     32'd4);
`ifdef DEC_BCD_BIN_EN
      chk("commit_bin",   32'(bus.bin_out),   32'd1984);
`endif
      tick(2);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk_idle("xfer1");

      // multi-hot error, then digit 3
      bus.key = 10'b0000100100;
      tick();
      chk("err_pulse", 32'(bus.err),   32'd1);
      chk("err_count", 32'(bus.count), 32'd0);
      tick();
      chk("err_width", 32'(bus.err), 32'd0);
      bus.key = '0;
      tick(2);
      bus.key = 10'b0000001000;
      tick();
      chk("d3_bcd", 32'(bus.bcd_out), 32'h0003);
      bus.key = '0;
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      chk_idle("clr0");

      // press 5 with enter from empty; DONE ignores keys while stalled
      bus.key = 10'd1 << 5;
      bus.enter = 1'b1;
      tick();
      bus.enter = 1'b0;
      chk("pe_valid", 32'(bus.out_valid), 32'd1);
      chk("pe_bcd",   32'(bus.bcd_out),   32'h0005);
      for (int i = 0; i < 5; i++) begin
         bus.key = (i % 2 == 0) ? 10'b0 : ((i == 3) ? 10'b0011000000 : 10'b0000000100);
         tick();
         chk("stall_bcd",   32'(bus.bcd_out),   32'h0005);
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_errovf", 32'({bus.err, bus.ovf}), 32'd0);
      end
      bus.key = '0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk_idle("xfer2");

      // overflowing press together with enter
      press_digit(2); press_digit(0); press_digit(2); press_digit(5);
      bus.key = 10'd1 << 6;
      bus.enter = 1'b1;
      tick();
      bus.enter = 1'b0;
      chk("ovfe_ovf",   32'(bus.ovf),       32'd1);
      chk("ovfe_valid", 32'(bus.out_valid), 32'd1);
      chk("ovfe_bcd",   32'(bus.bcd_out),   32'h2025);
`ifdef DEC_BCD_BIN_EN
      chk("ovfe_bin",   32'(bus.bin_out),   32'd2025);
`endif
      bus.key = '0;
      tick();
      chk("ovfe_width", 32'(bus.ovf), 32'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("xfer3_valid", 32'(bus.out_valid), 32'd0);

      // clr mid-entry, clr in DONE, rst mid-entry
      press_digit(2); press_digit(6);
      chk("e26_bcd", 32'(bus.bcd_out), 32'h0026);
      bus.clr = 1'b1; tick(); bus.clr = 1'b0;
      chk_idle("clr1");
      press_digit(3);
      chk("clr1_d3", 32'(bus.bcd_out), 32'h0003);
      bus.enter = 1'b1; tick(); bus.enter = 1'b0;
      chk("done3_valid", 32'(bus.out_valid), 32'd1);
      bus.clr = 1'b1; tick(); bus.clr = 1'b0;
      chk_idle("clr2");
      press_digit(3); press_digit(2); press_digit(6);
      chk("e326_bcd", 32'(bus.bcd_out), 32'h0326);
`ifdef DEC_BCD_BIN_EN
      chk("e326_bin", 32'(bus.bin_out), 32'd326);
`endif
      rst = 1'b1; tick(); rst = 1'b0;
      chk_idle("rst1");
      press_digit(3);
      chk("rst1_d3", 32'(bus.bcd_out), 32'h0003);
      bus.clr = 1'b1; tick(); bus.clr = 1'b0;

      // long hold of 9 counts once; enter with nothing entered
      bus.key = 10'b1000000000;
      tick(10);
      bus.key = '0;
      tick();
      chk("hold9_count", 32'(bus.count),   32'd1);
      chk("hold9_bcd",   32'(bus.bcd_out), 32'h0009);
      bus.clr = 1'b1; tick(); bus.clr = 1'b0;
      bus.enter = 1'b1; tick(); bus.enter = 1'b0;
      chk("empty_valid", 32'(bus.out_valid), 32'd1);
      chk("empty_bcd",   32'(bus.bcd_out),   32'd0);
      chk("empty_count", 32'(bus.count),     32'd0);
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      chk("empty_xfer", 32'(bus.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
